// File: rtl/imem_writer.sv
// imem_writer: byte-serial loader for the byte-addressed instruction memory.
// Accepts 32-bit words over valid/ready and writes each one as four bytes,
// most significant byte first, so the fetch path's {mem[a],..,mem[a+3]}
// read returns the word stored at a.
// Optional feature: define IMEM_WRITER_CHECKSUM_EN to build a running 32-bit
// sum of accepted words; otherwise the checksum port is tied to zero.
module imem_writer #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [31:0]       checksum
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_W0   = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_W2   = 3'd4;
    localparam logic [2:0] S_W3   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    // Highest base address at which a whole word still fits in memory.
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 4);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              overflow_q, overflow_d;

    logic              in_write;
    logic              handshake;
    logic              in_range;
    logic [ADDR_W-1:0] addr_plus4;
    logic [ADDR_W-1:0] cand_addr;
    logic [1:0]        byte_idx;

    assign in_write   = (state_q == S_W0) || (state_q == S_W1) ||
                        (state_q == S_W2) || (state_q == S_W3);
    assign word_ready = (state_q == S_LOAD) || ((state_q == S_W3) && !last_q);
    assign handshake  = word_valid && word_ready;
    assign addr_plus4 = addr_q + ADDR_W'(4);
    // A handshake in WRITE(3) is judged against the already-advanced address.
    assign cand_addr  = (state_q == S_W3) ? addr_plus4 : addr_q;
    assign in_range   = (cand_addr <= LAST_WORD_ADDR);
    assign byte_idx   = 2'(state_q - S_W0);

    // Next-state and datapath update for the session sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        last_d     = last_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d     = {base_addr[ADDR_W-1:2], 2'b00};
                    overflow_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_W0: state_d = S_W1;
            S_W1: state_d = S_W2;
            S_W2: state_d = S_W3;
            S_W3: begin
                addr_d  = addr_plus4;
                state_d = last_q ? S_DONE : S_LOAD;
            end
            default: state_d = state_q;
        endcase

        // word_ready is only high in LOAD or WRITE(3) with last clear, so this
        // covers both places a word can arrive.
        if (handshake) begin
            if (in_range) begin
                word_d  = word_in;
                last_d  = word_last;
                state_d = S_W0;
            end else begin
                overflow_d = 1'b1;
                state_d    = S_DONE;
            end
        end
    end

    // State registers; reset abandons any partially written word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    // Moore output decode: memory port is quiet (all zero) outside WRITE.
    always_comb begin
        mem_we    = in_write;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (in_write) begin
            mem_addr = addr_q + ADDR_W'(byte_idx);
            case (byte_idx)
                2'd0:    mem_wdata = word_q[31:24];
                2'd1:    mem_wdata = word_q[23:16];
                2'd2:    mem_wdata = word_q[15:8];
                default: mem_wdata = word_q[7:0];
            endcase
        end
    end

    assign busy     = (state_q == S_LOAD) || in_write;
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;

`ifdef IMEM_WRITER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Running sum: cleared when a session starts, bumped by each stored word.
    always_comb begin
        checksum_d = checksum_q;
        if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            checksum_d = 32'h0;
        end else if (handshake && in_range) begin
            checksum_d = checksum_q + word_in;
        end
    end

    // Checksum register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            checksum_q <= 32'h0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: doc/imem_writer.md
# imem_writer

Byte-serial loader that fills the byte-addressed instruction memory behind the fetch path. It accepts 32-bit instruction words over a valid/ready handshake and writes each word as four bytes, most significant byte first. The fetch path reads `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`, so it recovers exactly the word written at address a. The block sits between the program-load source (testbench/host/boot logic) and the memory write port, and is active before the PC starts fetching.

## Interface

**Parameters**
- MEM_BYTES, 1024: memory size in bytes; last writable word address is MEM_BYTES-4.
- ADDR_W, 32: width of base_addr and mem_addr.

**Ports**
- CLK  in  1  system clock; all state changes on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load session at base_addr; sampled only in IDLE or DONE.
- base_addr  in  ADDR_W  start byte address; bits [1:0] are ignored and forced to 0.
- word_in  in  32  instruction word to store.
- word_valid  in  1  word_in/word_last are valid.
- word_last  in  1  marks the final word of the session.
- word_ready  out  1  block can accept a word this cycle.
- mem_we  out  1  byte write strobe to memory.
- mem_addr  out  ADDR_W  byte address of the current write.
- mem_wdata  out  8  byte being written.
- busy  out  1  session in progress (LOAD or WRITE).
- done  out  1  session finished; level, held until next start.
- overflow  out  1  a word fell outside memory; sticky until next start.
- checksum  out  32  running sum of accepted words (see Configuration).

## Operation

- **States:** IDLE, LOAD, WRITE(k=0..3), DONE. All outputs are decoded from registered state (Moore).
- **IDLE.** word_ready=0, busy=0, done=0. If start=1: latch addr={base_addr[ADDR_W-1:2],2'b00}, clear overflow, go to LOAD.
- **LOAD.** word_ready=1, busy=1.
  - On word_valid&word_ready with addr<=MEM_BYTES-4: latch word and last, go to WRITE(0).
  - On a handshake with addr>MEM_BYTES-4: consume and discard the word, set overflow=1, go to DONE.
- **WRITE(k).**
  - mem_we=1, mem_addr=addr+k, mem_wdata=word[31-8k -: 8].
  - k=0..2 advance to k+1.
  - At k=3: addr+=4, then:
    - if latched last=1, go to DONE;
    - else if a word handshake occurs in this cycle, treat it exactly as a LOAD handshake against the new addr;
    - else go to LOAD.
- **word_ready** is 1 in LOAD, and in WRITE(3) when latched last=0. It is 0 otherwise.
- **DONE.** done=1, busy=0, word_ready=0. start=1 begins a new session as from IDLE. start during LOAD/WRITE is ignored.
- **Addresses.** addr wraps modulo 2^ADDR_W arithmetically, but the overflow check is applied before any write, so no write ever targets >=MEM_BYTES.
- **Reset (any state, including mid-WRITE).** Go to IDLE immediately.
  - All outputs go to 0: mem_we, mem_addr, mem_wdata, word_ready, busy, done, overflow, checksum.
  - A partially written word is not completed.

## Timing

- start sampled at edge e: word_ready=1 in the cycle after e.
- Word accepted at edge n: mem_we=1 for cycles n+1..n+4, with addresses addr..addr+3, MSB byte first.
- Sustained throughput is 1 word per 4 cycles with no mem_we bubble when word_valid is held.
- last word accepted at edge n: done=1 from cycle n+5; busy=0 from n+5.
- Overflow handshake at edge n: done=1 and overflow=1 from n+1; no mem_we.
- word_valid may drop at any time. A word is transferred only on a cycle with word_valid=1 and word_ready=1.

## Configuration

- Macro: **IMEM_WRITER_CHECKSUM_EN**.
- **Defined:** checksum is a 32-bit register.
  - Cleared on start.
  - On each accepted, non-discarded word: checksum += word_in, modulo 2^32.
  - Stable while in DONE.
- **Undefined:** no checksum register is built; the checksum port is tied to 32'h0.

## Test plan

- **Reset:** assert RST_N=0 mid-session, then release -> all outputs 0, state IDLE, word_ready=0 until next start.
- **Single word:** start with base_addr=0, then word 0x12345678 with word_last=1 -> writes 0x12@0, 0x34@1, 0x56@2, 0x78@3 on 4 consecutive cycles; done=1 the next cycle; overflow=0.
- **Back-to-back:** base_addr=0x13 (forced to 0x10); words 0xAABBCCDD then 0x01020304 (last), word_valid held -> 8 consecutive mem_we cycles at 0x10..0x17 with bytes AA,BB,CC,DD,01,02,03,04. With IMEM_WRITER_CHECKSUM_EN defined, checksum=0xABBDCFE1.
- **Gapped valid:** deassert word_valid for 3 cycles between words -> mem_we low during the gap; no duplicate or dropped bytes; word_ready stays 1 in LOAD.
- **Overflow:** base_addr=1020 (MEM_BYTES=1024); words 0xDEADBEEF, 0x11111111 (last) -> first word written at 1020..1023; second word consumed and discarded; overflow=1, done=1; no write to addr>=1024.
- **Reset mid-WRITE:** pull RST_N low during WRITE(1) -> mem_we drops to 0 immediately; bytes 2–3 are never written; after release and a new start, writing resumes correctly at the new base_addr.
